// File: rtl/spi_stream_pkg.sv
// Shared types and escape-layer constants for the SPI stream master.
// Latency: n/a (package). Backpressure: n/a.
package spi_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD
  } state_e;

  localparam logic [7:0] ESC_IDLE = 8'h4A;
  localparam logic [7:0] ESC_CHAR = 8'h4D;
  localparam logic [7:0] ESC_XOR  = 8'h20;

  function automatic logic needs_escape(input logic [7:0] b);
    return (b == ESC_IDLE) || (b == ESC_CHAR);
  endfunction

endpackage

// File: rtl/spi_stream_master_if.sv
// Byte-stream handshake and SPI pins for the SPI stream master.
// master: the SPI master's own view; slave: the view of the environment that drives it.
interface spi_stream_master_if;

  logic [7:0] iTX_DATA;
  logic       iTX_LAST;
  logic       iTX_VALID;
  logic       oTX_READY;
  logic [7:0] oRX_DATA;
  logic       oRX_VALID;
  logic       oBUSY;
  logic       oSPI_SCLK;
  logic       oSPI_MOSI;
  logic       iSPI_MISO;
  logic       oSPI_CSn;

  modport master (
    input  iTX_DATA, iTX_LAST, iTX_VALID, iSPI_MISO,
    output oTX_READY, oRX_DATA, oRX_VALID, oBUSY, oSPI_SCLK, oSPI_MOSI, oSPI_CSn
  );

  modport slave (
    output iTX_DATA, iTX_LAST, iTX_VALID, iSPI_MISO,
    input  oTX_READY, oRX_DATA, oRX_VALID, oBUSY, oSPI_SCLK, oSPI_MOSI, oSPI_CSn
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV cycles per half-period, idles low; rise/fall strobe the edge on which SCLK toggles.
// Latency: SCLK registered, strobes combinational from the counter. Backpressure: none (restart forces low).
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  always_comb begin
    tick   = en && (cnt_q == CNT_MAX);
    rise   = tick && !sclk_q;
    fall   = tick && sclk_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (restart) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_stream_master.sv
// Mode-0 SPI master: valid/ready bytes out on MOSI, every captured MISO byte strobed back; 16*CLK_DIV cycles per byte.
// TX ready only in IDLE/WAIT; RX has no backpressure. SPI_STREAM_ESCAPE_EN enables idle/escape byte-stuffing.
module spi_stream_master
  import spi_stream_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  spi_stream_master_if.master  io
);

`ifdef SPI_STREAM_ESCAPE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_byte_q, pend_byte_d;
  logic             csn_q, csn_d;
  logic             tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_esc_q, rx_esc_d;

  logic       sclk, sclk_rise, sclk_fall;
  logic       accept, byte_end;
  logic       load_esc;
  logic [7:0] load_byte;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk     (iCLK),
    .rst     (iRESET),
    .en      (state_q == ST_SHIFT),
    .restart (state_q != ST_SHIFT),
    .sclk    (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // An escaped input byte goes out as ESC_CHAR first; its XORed form waits in pend_byte.
  always_comb begin
    load_esc  = ESC_EN && needs_escape(io.iTX_DATA);
    load_byte = load_esc ? ESC_CHAR : io.iTX_DATA;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    last_d      = last_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    csn_d       = csn_q;
    tx_ready_d  = 1'b0;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_esc_d    = rx_esc_q;
    accept      = io.iTX_VALID && tx_ready_q;
    byte_end    = 1'b0;

    if (sclk_rise) begin
      rx_sr_d = {rx_sr_q[6:0], io.iSPI_MISO};
    end
    // MOSI keeps the last bit after the 8th fall so it is held through WAIT.
    if (sclk_fall) begin
      if (bit_q == 3'd7) begin
        byte_end = 1'b1;
        bit_d    = 3'd0;
      end else begin
        bit_d   = bit_q + 3'd1;
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_sr_d     = load_byte;
          pend_d      = load_esc;
          pend_byte_d = io.iTX_DATA ^ ESC_XOR;
          last_d      = io.iTX_LAST;
          bit_d       = 3'd0;
          cnt_d       = CNT_W'(CS_SETUP - 1);
          csn_d       = 1'b0;
          state_d     = ST_SETUP;
        end else begin
          tx_ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (byte_end) begin
          if (pend_q) begin
            tx_sr_d = pend_byte_q;
            pend_d  = 1'b0;
          end else if (last_q) begin
            cnt_d   = CNT_W'(CS_HOLD);
            state_d = ST_HOLD;
          end else begin
            tx_ready_d = 1'b1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (accept) begin
          tx_sr_d     = load_byte;
          pend_d      = load_esc;
          pend_byte_d = io.iTX_DATA ^ ESC_XOR;
          last_d      = io.iTX_LAST;
          bit_d       = 3'd0;
          state_d     = ST_SHIFT;
        end else begin
          tx_ready_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // HOLD is entered on the strobe cycle, so it spans CS_HOLD+1 cycles.
        if (cnt_q == '0) begin
          csn_d      = 1'b1;
          rx_esc_d   = 1'b0;
          tx_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (byte_end) begin
      if (ESC_EN && rx_esc_q) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_sr_q ^ ESC_XOR;
        rx_esc_d   = 1'b0;
      end else if (ESC_EN && (rx_sr_q == ESC_CHAR)) begin
        rx_esc_d = 1'b1;
      end else if (!(ESC_EN && (rx_sr_q == ESC_IDLE))) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_sr_q;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 8'h00;
      last_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
      csn_q       <= 1'b1;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_esc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      csn_q       <= csn_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_esc_q    <= rx_esc_d;
    end
  end

  assign io.oTX_READY = tx_ready_q;
  assign io.oRX_DATA  = rx_data_q;
  assign io.oRX_VALID = rx_valid_q;
  assign io.oBUSY     = ~csn_q;
  assign io.oSPI_SCLK = sclk;
  assign io.oSPI_MOSI = tx_sr_q[7];
  assign io.oSPI_CSn  = csn_q;

endmodule
